// File: rtl/ad_bus_pkg.sv
// rtl/ad_bus_pkg.sv - shared types and sizing helper for the AD bus sequencer
package ad_bus_pkg;

    // Bus phase sequence: IDLE -> ALE -> AHOLD -> STROBE -> RECOVER -> IDLE
    typedef enum logic [2:0] {
        IDLE,
        ALE,
        AHOLD,
        STROBE,
        RECOVER
    } ad_state_t;

    // Width of a down-counter that must hold the largest phase length minus one
    // (sized for max+1 so a single-cycle maximum still gets one bit).
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ad_bus_sequencer.sv
// rtl/ad_bus_sequencer.sv - multiplexed address/data bus sequencer for an external octal latch
//
// Purpose: turns one CPU-side request into an ALE / latch-hold / RD_n-WR_n strobe /
// recovery sequence on a multiplexed AD bus and returns one completion pulse.
// Every output is a flop; next-cycle output values are decoded from the next state.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_addr[15:0]          [7:0] multiplexed on AD, [15:8] on a_hi
//   req_we, req_wdata[7:0]  write select and write data
//   rsp_valid, rsp_rdata    one-cycle completion pulse, read data (held until next read)
//   ad_out, ad_oe, ad_in    AD pad drive value, drive enable, sampled value
//   a_hi                    non-multiplexed high address (held after completion)
//   ale, rd_n, wr_n         latch enable (high), read/write strobes (low)
module ad_bus_sequencer
    import ad_bus_pkg::*;
#(
    parameter int ALE_CYC    = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic [7:0]  a_hi,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n
);

    localparam int CNT_W = cnt_w(ALE_CYC, STROBE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] ALE_LD    = CNT_W'(ALE_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    generate
        if (ALE_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_param_check
            $error("ad_bus_sequencer: ALE_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
        end
    endgenerate

    ad_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [15:0]      r_addr;
    logic [7:0]       r_wdata;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic [7:0]       r_ad_out;
    logic             r_ad_oe;
    logic [7:0]       r_a_hi;
    logic             r_ale;
    logic             r_rd_n;
    logic             r_wr_n;

    ad_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_sample;
    logic             w_done;
    logic             w_we_nxt;
    logic [15:0]      w_addr_nxt;
    logic [7:0]       w_wdata_nxt;

    logic             w_req_ready_nxt;
    logic [7:0]       w_ad_out_nxt;
    logic             w_ad_oe_nxt;
    logic [7:0]       w_a_hi_nxt;
    logic             w_ale_nxt;
    logic             w_rd_n_nxt;
    logic             w_wr_n_nxt;

    // Next-state logic. The counter is loaded with (phase length - 1) on entry
    // and the phase ends on the cycle it reads zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ALE;
                    w_cnt_nxt   = ALE_LD;
                end
            end
            ALE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = AHOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            AHOLD: begin
                w_state_nxt = STROBE;
                w_cnt_nxt   = STROBE_LD;
            end
            STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RECOVER;
                    w_cnt_nxt   = HOLD_LD;
                    // Read data is taken at the edge that ends the strobe,
                    // while rd_n is still low at the device.
                    w_sample    = ~r_we;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_we_nxt    = w_accept ? req_we    : r_we;
    assign w_addr_nxt  = w_accept ? req_addr  : r_addr;
    assign w_wdata_nxt = w_accept ? req_wdata : r_wdata;

    // Output decode from the next state so every pin comes straight off a flop.
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_ale_nxt       = (w_state_nxt == ALE);
        w_rd_n_nxt      = ~((w_state_nxt == STROBE) && !w_we_nxt);
        w_wr_n_nxt      = ~((w_state_nxt == STROBE) &&  w_we_nxt);
        w_ad_oe_nxt     = (w_state_nxt == ALE) || (w_state_nxt == AHOLD) ||
                          (((w_state_nxt == STROBE) || (w_state_nxt == RECOVER)) && w_we_nxt);
        w_a_hi_nxt      = (w_state_nxt == ALE) ? w_addr_nxt[15:8] : r_a_hi;
        w_ad_out_nxt    = r_ad_out;
        if (w_state_nxt == ALE) begin
            w_ad_out_nxt = w_addr_nxt[7:0];
        end else if ((w_state_nxt == STROBE) && w_we_nxt) begin
            w_ad_out_nxt = w_wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ad_out    <= '0;
            r_ad_oe     <= 1'b0;
            r_a_hi      <= '0;
            r_ale       <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_done;
            r_rsp_rdata <= w_sample ? ad_in : r_rsp_rdata;
            r_ad_out    <= w_ad_out_nxt;
            r_ad_oe     <= w_ad_oe_nxt;
            r_a_hi      <= w_a_hi_nxt;
            r_ale       <= w_ale_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign ad_out    = r_ad_out;
    assign ad_oe     = r_ad_oe;
    assign a_hi      = r_a_hi;
    assign ale       = r_ale;
    assign rd_n      = r_rd_n;
    assign wr_n      = r_wr_n;

endmodule
